// File: rtl/execute_stage_if.sv
// Signal bundle between fetch, the execute stage, the data RAM and the redirect path.
// The execute stage uses the slave modport; the fetch/RAM side uses master.
interface execute_stage_if;
  logic [4:0] instr_in;
  logic [2:0] addr_mode_in;
  logic [7:0] data_in;
  logic [7:0] pc_in;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] CPUinput;
  logic [7:0] CPUoutput;
  logic [7:0] dmem_addr;
  logic [7:0] dmem_wdata;
  logic [7:0] dmem_rdata;
  logic       dmem_re;
  logic       dmem_we;
  logic       br_taken;
  logic [7:0] br_target;
  logic [7:0] acc_out;
  logic       flag_z;
  logic       flag_c;
  logic       halted;

  modport master (
    output instr_in, addr_mode_in, data_in, pc_in, in_valid, CPUinput, dmem_rdata,
    input  in_ready, CPUoutput, dmem_addr, dmem_wdata, dmem_re, dmem_we,
           br_taken, br_target, acc_out, flag_z, flag_c, halted
  );

  modport slave (
    input  instr_in, addr_mode_in, data_in, pc_in, in_valid, CPUinput, dmem_rdata,
    output in_ready, CPUoutput, dmem_addr, dmem_wdata, dmem_re, dmem_we,
           br_taken, br_target, acc_out, flag_z, flag_c, halted
  );
endinterface

// File: rtl/execute_stage.sv
// Accumulator execute stage: ALU ops with immediate/direct/indirect operands, STA,
// jumps with a one-cycle redirect pulse, port I/O and halt.
//
// state | meaning
// IDLE  | ready to accept an instruction (in_ready=1)
// WAITP | pointer read outstanding; issue the final read or the indirect write
// WAITD | operand read outstanding; execute with dmem_rdata on the next edge
// HALT  | stopped until reset
module execute_stage (
  input  logic     clk,
  input  logic     reset,
  execute_stage_if.slave bus
);
  localparam logic [4:0] OP_LDA = 5'b00001;
  localparam logic [4:0] OP_STA = 5'b00010;
  localparam logic [4:0] OP_ADD = 5'b00011;
  localparam logic [4:0] OP_SUB = 5'b00100;
  localparam logic [4:0] OP_AND = 5'b00101;
  localparam logic [4:0] OP_OR  = 5'b00110;
  localparam logic [4:0] OP_NOT = 5'b00111;
  localparam logic [4:0] OP_JMP = 5'b01000;
  localparam logic [4:0] OP_JZ  = 5'b01001;
  localparam logic [4:0] OP_JC  = 5'b01010;
  localparam logic [4:0] OP_IN  = 5'b01011;
  localparam logic [4:0] OP_OUT = 5'b01100;
  localparam logic [4:0] OP_HLT = 5'b11111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAITP = 2'd1,
    WAITD = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t     state;
  state_t     nextState;
  logic [4:0] opLat;

  logic [7:0] acc;
  logic [7:0] cpuOut;
  logic [7:0] brTarget;
  logic       flagZ;
  logic       flagC;
  logic       brTaken;
  logic       haltedReg;

  logic       accept;
  logic       isAlu;
  logic       isSta;
  logic       modeDir;
  logic       modeInd;
  logic       modePcRel;

  logic       aluFire;
  logic [4:0] aluOp;
  logic [7:0] aluOperand;
  logic [7:0] aluResult;
  logic [8:0] sum9;
  logic       noBorrow;

  logic       jumpTaken;
  logic [7:0] jumpTarget;

  assign modeDir   = (bus.addr_mode_in == 3'b001);
  assign modeInd   = (bus.addr_mode_in == 3'b010);
  assign modePcRel = (bus.addr_mode_in == 3'b011);
  assign isAlu     = bus.instr_in inside {OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR};
  assign isSta     = (bus.instr_in == OP_STA);

  // Gating with reset keeps the handshake and strobes quiet during the reset cycle.
  assign accept = (state == IDLE) && bus.in_valid && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      opLat <= '0;
    end else begin
      state <= nextState;
      if (accept) opLat <= bus.instr_in;
    end
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (bus.instr_in == OP_HLT)                nextState = HALT;
          else if (isAlu && modeDir)                 nextState = WAITD;
          else if ((isAlu || isSta) && modeInd)      nextState = WAITP;
          else                                       nextState = IDLE;
        end
      end
      WAITP:   nextState = (opLat == OP_STA) ? IDLE : WAITD;
      WAITD:   nextState = IDLE;
      HALT:    nextState = HALT;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready   = (state == IDLE) && !reset;
    bus.dmem_re    = 1'b0;
    bus.dmem_we    = 1'b0;
    bus.dmem_addr  = 8'h00;
    bus.dmem_wdata = 8'h00;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if ((isAlu && (modeDir || modeInd)) || (isSta && modeInd)) begin
            bus.dmem_re   = 1'b1;
            bus.dmem_addr = bus.data_in;
          end else if (isSta && modeDir) begin
            bus.dmem_we    = 1'b1;
            bus.dmem_addr  = bus.data_in;
            bus.dmem_wdata = acc;
          end
        end
      end
      WAITP: begin
        // The pointer just read is the effective address of the second access.
        if (!reset) begin
          if (opLat == OP_STA) begin
            bus.dmem_we    = 1'b1;
            bus.dmem_addr  = bus.dmem_rdata;
            bus.dmem_wdata = acc;
          end else begin
            bus.dmem_re   = 1'b1;
            bus.dmem_addr = bus.dmem_rdata;
          end
        end
      end
      default: ;
    endcase
  end

  assign aluOp      = (state == WAITD) ? opLat : bus.instr_in;
  assign aluOperand = (state == WAITD) ? bus.dmem_rdata : bus.data_in;
  assign aluFire    = (state == WAITD) || (accept && isAlu && !modeDir && !modeInd);
  assign sum9       = {1'b0, acc} + {1'b0, aluOperand};
  assign noBorrow   = (acc >= aluOperand);

  always_comb begin
    aluResult = aluOperand;
    case (aluOp)
      OP_ADD:  aluResult = sum9[7:0];
      OP_SUB:  aluResult = acc - aluOperand;
      OP_AND:  aluResult = acc & aluOperand;
      OP_OR:   aluResult = acc | aluOperand;
      default: aluResult = aluOperand;
    endcase
  end

  // Conditions use the flags as registered, i.e. before this instruction's edge.
  assign jumpTarget = modePcRel ? (bus.pc_in + bus.data_in) : bus.data_in;
  assign jumpTaken  = accept && ((bus.instr_in == OP_JMP) ||
                                 ((bus.instr_in == OP_JZ) && flagZ) ||
                                 ((bus.instr_in == OP_JC) && flagC));

  always_ff @(posedge clk) begin
    if (reset) begin
      acc       <= 8'h00;
      cpuOut    <= 8'h00;
      flagZ     <= 1'b0;
      flagC     <= 1'b0;
      brTaken   <= 1'b0;
      brTarget  <= 8'h00;
      haltedReg <= 1'b0;
    end else begin
      brTaken <= jumpTaken;
      if (jumpTaken) brTarget <= jumpTarget;
      if (aluFire) begin
        acc   <= aluResult;
        flagZ <= (aluResult == 8'h00);
        if (aluOp == OP_ADD)      flagC <= sum9[8];
        else if (aluOp == OP_SUB) flagC <= noBorrow;
      end
      if (accept) begin
        case (bus.instr_in)
          OP_NOT: begin
            acc   <= ~acc;
            flagZ <= (acc == 8'hFF);
          end
          OP_IN: begin
            acc   <= bus.CPUinput;
            flagZ <= (bus.CPUinput == 8'h00);
          end
          OP_OUT:  cpuOut    <= acc;
          OP_HLT:  haltedReg <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign bus.acc_out   = acc;
  assign bus.CPUoutput = cpuOut;
  assign bus.flag_z    = flagZ;
  assign bus.flag_c    = flagC;
  assign bus.br_taken  = brTaken;
  assign bus.br_target = brTarget;
  assign bus.halted    = haltedReg;
endmodule
